// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared 16-bit ALU.
// Each grant is latched, given EXEC_CYCLES to settle, then answered to the winner only.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic [15:0] alu_mode,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  output logic        busy
);

  localparam logic [3:0] OP_ADD   = 4'd7;
  localparam logic [3:0] OP_SUB   = 4'd8;
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last;
  logic        r_win;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_mode;
  logic [1:0]  r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_carry;
  logic        r_rsp_err;

  logic [3:0]  w_op [2];
  logic [15:0] w_a  [2];
  logic [15:0] w_b  [2];
  logic        w_win;
  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_capture;
  logic        w_release;
  logic        w_legal;
  logic        w_arith;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign w_op[gi] = req_op[4*gi +: 4];
      assign w_a[gi]  = req_a[16*gi +: 16];
      assign w_b[gi]  = req_b[16*gi +: 16];
    end
  endgenerate

  // A tie goes to whichever requester was not granted last.
  assign w_win = (req_valid == 2'b10) | ((req_valid == 2'b11) & ~r_last);

  always_comb begin
    w_state_next = r_state;
    w_grant      = 2'b00;
    case (r_state)
      S_IDLE: begin
        w_grant[w_win] = req_valid[w_win];
        if (|w_grant) w_state_next = S_EXEC;
      end
      S_EXEC: if (r_cnt == 4'd0) w_state_next = S_RESP;
      S_RESP: if (rsp_ready[r_win]) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept  = |w_grant;
  assign w_capture = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_release = (r_state == S_RESP) && rsp_ready[r_win];
  assign w_legal   = (r_op <= OP_SUB);
  assign w_arith   = (r_op == OP_ADD) || (r_op == OP_SUB);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last      <= 1'b1;
      r_win       <= 1'b0;
      r_cnt       <= 4'd0;
      r_op        <= 4'd0;
      r_a         <= 16'd0;
      r_b         <= 16'd0;
      r_mode      <= 16'd0;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= 16'd0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_win  <= w_win;
        r_last <= w_win;
        r_op   <= w_op[w_win];
        r_a    <= w_a[w_win];
        r_b    <= w_b[w_win];
        r_mode <= (w_op[w_win] == OP_SUB) ? 16'hFFFF : 16'h0000;
        r_cnt  <= CNT_LOAD;
      end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Illegal opcodes report an error with a clean zero result, whatever the ALU returns.
      if (w_capture) begin
        r_rsp_valid <= r_win ? 2'b10 : 2'b01;
        r_rsp_data  <= w_legal ? alu_result : 16'h0000;
        r_rsp_carry <= w_arith & alu_carry;
        r_rsp_err   <= ~w_legal;
      end
      if (w_release) r_rsp_valid <= 2'b00;
    end
  end

  assign req_ready = rst_n ? w_grant : 2'b00;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_err   = r_rsp_err;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_op;
  assign alu_mode  = r_mode;
  assign busy      = (r_state != S_IDLE);

endmodule
